// File: rtl/rice_core_lsu.sv
// rice_core_lsu: load/store unit between the execute stage and a ready/valid data bus.
// One access in flight at a time through IDLE -> REQUEST -> RESPONSE -> DONE.
// Optional feature: define RICE_CORE_LSU_MISALIGN_CHECK_EN to trap misaligned
// halfword/word accesses locally instead of issuing them on the bus.
`timescale 1ns/1ps

module rice_core_lsu #(
    parameter int XLEN = 32
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            i_valid,
    output logic            o_ready,
    input  logic [1:0]      i_access_type,
    input  logic [2:0]      i_access_mode,
    input  logic [XLEN-1:0] i_address,
    input  logic [XLEN-1:0] i_store_data,
    output logic            o_request_valid,
    input  logic            i_request_ready,
    output logic            o_request_write,
    output logic [XLEN-1:0] o_request_address,
    output logic [3:0]      o_request_strobe,
    output logic [XLEN-1:0] o_request_data,
    input  logic            i_response_valid,
    output logic            o_response_ready,
    input  logic [XLEN-1:0] i_response_data,
    input  logic            i_response_error,
    output logic            o_result_valid,
    output logic [XLEN-1:0] o_result_data,
    output logic            o_result_error,
    output logic            o_misaligned
);

    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_REQUEST  = 2'd1;
    localparam logic [1:0] ST_RESPONSE = 2'd2;
    localparam logic [1:0] ST_DONE     = 2'd3;

    localparam logic [1:0] TYPE_STORE = 2'd1;
    localparam logic [1:0] TYPE_LOAD  = 2'd2;

    logic [1:0]      state;
    logic [XLEN-1:0] addr_q;
    logic [XLEN-1:0] store_data_q;
    logic [2:0]      mode_q;
    logic            write_q;
    logic [XLEN-1:0] result_data_q;
    logic            result_error_q;
    logic            accept;
    logic            misalign_now;
    logic            go_direct;
    logic            req_active;
    logic            done;

    // Byte lanes touched by the access; mode[1:0] selects size, codes 10/11 are word.
    function automatic logic [3:0] lane_strobe(input logic [2:0] mode, input logic [1:0] off);
        case (mode[1:0])
            2'b00:   return 4'b0001 << off;
            2'b01:   return 4'b0011 << {off[1], 1'b0};
            default: return 4'b1111;
        endcase
    endfunction

    // Store data replicated across all lanes so the strobe alone picks the target bytes.
    function automatic logic [XLEN-1:0] lane_data(input logic [2:0] mode, input logic [XLEN-1:0] data);
        case (mode[1:0])
            2'b00:   return {4{data[7:0]}};
            2'b01:   return {2{data[15:0]}};
            default: return data;
        endcase
    endfunction

    // Align the addressed bytes down to bit 0, then sign- or zero-extend (mode[2] = unsigned).
    function automatic logic [XLEN-1:0] load_extend(input logic [2:0] mode, input logic [1:0] off,
                                                   input logic [XLEN-1:0] raw);
        logic [XLEN-1:0] shifted;
        shifted = raw >> {off, 3'b000};
        case (mode[1:0])
            2'b00:   return {{(XLEN-8){shifted[7] & ~mode[2]}}, shifted[7:0]};
            2'b01:   return {{(XLEN-16){shifted[15] & ~mode[2]}}, shifted[15:0]};
            default: return shifted;
        endcase
    endfunction

    assign accept = i_valid && (state == ST_IDLE) &&
                    ((i_access_type == TYPE_STORE) || (i_access_type == TYPE_LOAD));

`ifdef RICE_CORE_LSU_MISALIGN_CHECK_EN
    logic misaligned_q;

    function automatic logic is_misaligned(input logic [2:0] mode, input logic [1:0] off);
        case (mode[1:0])
            2'b00:   return 1'b0;
            2'b01:   return off[0];
            default: return off != 2'b00;
        endcase
    endfunction

    assign misalign_now = is_misaligned(i_access_mode, i_address[1:0]);

    // Remember whether the accepted access was trapped as misaligned.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n)
            misaligned_q <= 1'b0;
        else if (accept)
            misaligned_q <= misalign_now;
    end

    assign o_misaligned = done && misaligned_q;
`else
    assign misalign_now = 1'b0;
    assign o_misaligned = 1'b0;
`endif

    assign go_direct = accept && misalign_now;

    // Access sequencing; only the state register needs reset, outputs are gated by it.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state <= ST_IDLE;
        end else begin
            case (state)
                ST_IDLE:     if (accept) state <= go_direct ? ST_DONE : ST_REQUEST;
                ST_REQUEST:  if (i_request_ready) state <= ST_RESPONSE;
                ST_RESPONSE: if (i_response_valid) state <= ST_DONE;
                default:     state <= ST_IDLE;
            endcase
        end
    end

    // Command capture at acceptance; held unchanged for the whole access.
    always_ff @(posedge i_clk) begin
        if (accept) begin
            addr_q       <= i_address;
            mode_q       <= i_access_mode;
            store_data_q <= i_store_data;
            write_q      <= (i_access_type == TYPE_STORE);
        end
    end

    // Result capture from the bus response, or a zero result for a locally trapped access.
    always_ff @(posedge i_clk) begin
        if (state == ST_RESPONSE && i_response_valid) begin
            result_data_q  <= write_q ? '0 : load_extend(mode_q, addr_q[1:0], i_response_data);
            result_error_q <= i_response_error;
        end else if (go_direct) begin
            result_data_q  <= '0;
            result_error_q <= 1'b0;
        end
    end

    assign req_active = (state == ST_REQUEST);
    assign done       = (state == ST_DONE);

    assign o_ready           = (state == ST_IDLE);
    assign o_request_valid   = req_active;
    assign o_request_write   = req_active && write_q;
    assign o_request_address = req_active ? {addr_q[XLEN-1:2], 2'b00} : '0;
    assign o_request_strobe  = req_active ? lane_strobe(mode_q, addr_q[1:0]) : 4'b0000;
    assign o_request_data    = req_active ? lane_data(mode_q, store_data_q) : '0;
    assign o_response_ready  = (state == ST_RESPONSE);
    assign o_result_valid    = done;
    assign o_result_data     = done ? result_data_q : '0;
    assign o_result_error    = done && result_error_q;

endmodule
